// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster bus between the timing generator and draw stages
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running raster counter with blanking, sync and line/frame strobes
module vga_timing_gen #(
  parameter int H_VISIBLE    = 800,
  parameter int H_SYNC_START = 840,
  parameter int H_SYNC_END   = 968,
  parameter int H_TOTAL      = 1056,
  parameter int V_VISIBLE    = 600,
  parameter int V_SYNC_START = 601,
  parameter int V_SYNC_END   = 605,
  parameter int V_TOTAL      = 628
) (
  input  logic clk,
  input  logic rst,
  vga_if.out   vga_out,
  output logic line_start,
  output logic frame_start
);

  generate
    if (!(H_VISIBLE > 0 && H_VISIBLE < H_SYNC_START && H_SYNC_START < H_SYNC_END &&
          H_SYNC_END <= H_TOTAL && H_TOTAL <= 2048 &&
          V_VISIBLE > 0 && V_VISIBLE < V_SYNC_START && V_SYNC_START < V_SYNC_END &&
          V_SYNC_END <= V_TOTAL && V_TOTAL <= 2048)) begin : g_bad_params
      $fatal(1, "vga_timing_gen: inconsistent timing parameters");
    end
  endgenerate

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SS   = 11'(H_SYNC_START);
  localparam logic [10:0] H_SE   = 11'(H_SYNC_END);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SS   = 11'(V_SYNC_START);
  localparam logic [10:0] V_SE   = 11'(V_SYNC_END);

  logic        run_q;
  logic [10:0] h_q, v_q, h_next, v_next;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic [11:0] rgb_q;

  // run_q holds the counters at (0,0) for the first edge after reset
  always_comb begin
    h_next = '0;
    v_next = '0;
    if (run_q) begin
      if (h_q == H_LAST) begin
        h_next = '0;
        v_next = (v_q == V_LAST) ? 11'd0 : 11'(v_q + 11'd1);
      end else begin
        h_next = 11'(h_q + 11'd1);
        v_next = v_q;
      end
    end
  end

  // Flags decode the next counter values so every field lands on the same pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q       <= 1'b0;
      h_q         <= '0;
      v_q         <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      rgb_q       <= 12'h000;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      h_q         <= h_next;
      v_q         <= v_next;
      hblnk_q     <= (h_next >= H_VIS);
      hsync_q     <= (h_next >= H_SS) && (h_next < H_SE);
      vblnk_q     <= (v_next >= V_VIS);
      vsync_q     <= (v_next >= V_SS) && (v_next < V_SE);
      rgb_q       <= 12'h000;
      line_start  <= (h_next == 11'd0);
      frame_start <= (h_next == 11'd0) && (v_next == 11'd0);
    end
  end

  assign vga_out.hcount = h_q;
  assign vga_out.vcount = v_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen at default and reduced timings
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic        ls;
    logic        fs;
  } vga_t;

  logic clk;
  logic rst;
  logic ls_d, fs_d, ls_s, fs_s;

  vga_if vif_d();
  vga_if vif_s();

  vga_timing_gen u_def (
    .clk         (clk),
    .rst         (rst),
    .vga_out     (vif_d),
    .line_start  (ls_d),
    .frame_start (fs_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(10), .H_SYNC_START(12), .H_SYNC_END(15), .H_TOTAL(18),
    .V_VISIBLE(6),  .V_SYNC_START(7),  .V_SYNC_END(9),  .V_TOTAL(11)
  ) u_small (
    .clk         (clk),
    .rst         (rst),
    .vga_out     (vif_s),
    .line_start  (ls_s),
    .frame_start (fs_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: one pixel-clock edge of an ideal raster counter
  function automatic vga_t model_step(input bit r, inout int h, inout int v, inout bit run,
                                      input int hvis, input int hss, input int hse, input int ht,
                                      input int vvis, input int vss, input int vse, input int vt);
    vga_t e;
    e = '0;
    if (r) begin
      h = 0; v = 0; run = 0;
      return e;
    end
    if (!run) begin
      h = 0; v = 0; run = 1;
    end else begin
      h = h + 1;
      if (h == ht) begin
        h = 0;
        v = v + 1;
        if (v == vt) v = 0;
      end
    end
    e.h   = 11'(h);
    e.v   = 11'(v);
    e.hb  = (h >= hvis);
    e.hs  = (h >= hss) && (h < hse);
    e.vb  = (v >= vvis);
    e.vs  = (v >= vss) && (v < vse);
    e.rgb = 12'h000;
    e.ls  = (h == 0);
    e.fs  = (h == 0) && (v == 0);
    return e;
  endfunction

  vga_t qd[$];
  vga_t qs[$];
  int dh = 0, dv = 0, sh = 0, sv = 0;
  bit drun = 0, srun = 0;
  vga_t gd, gs, pd, ps;

  int  cyc = 0;
  int  rel_cyc = -1;
  bit  track_en = 0;
  bit  hb_done = 0, hs_rise_done = 0, hs_fall_done = 0;
  int  hs_cnt = 0;
  int  last_ls_d = -1, ls_cnt_d = 0;
  bit  lwrap_seen = 0;
  int  last_fs_s = -1, ls_in_frame = 0, fs_win = 0, fwrap_cnt = 0;

  task automatic cycle(input bit r);
    @(negedge clk);
    rst = r;
    qd.push_back(model_step(r, dh, dv, drun, 800, 840, 968, 1056, 600, 601, 605, 628));
    qs.push_back(model_step(r, sh, sv, srun, 10, 12, 15, 18, 6, 7, 9, 11));
    @(posedge clk);
    #1;
    cyc++;
    gd = {vif_d.hcount, vif_d.vcount, vif_d.hsync, vif_d.vsync, vif_d.hblnk, vif_d.vblnk,
          vif_d.rgb, ls_d, fs_d};
    gs = {vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync, vif_s.hblnk, vif_s.vblnk,
          vif_s.rgb, ls_s, fs_s};
    check("def_model", 64'(gd), 64'(qd.pop_front()));
    check("small_model", 64'(gs), 64'(qs.pop_front()));
    if (track_en) begin
      if (rel_cyc < 0) rel_cyc = cyc;
      if (!pd.hb && gd.hb && !hb_done) begin
        check("hblnk_rise_h", 64'(gd.h), 64'd800);
        hb_done = 1;
      end
      if (!pd.hs && gd.hs && !hs_rise_done) begin
        check("hsync_rise_h", 64'(gd.h), 64'd840);
        hs_rise_done = 1;
      end
      if (pd.hs && !gd.hs && !hs_fall_done) begin
        check("hsync_fall_h", 64'(gd.h), 64'd968);
        hs_fall_done = 1;
      end
      if (gd.hs && gd.v == 11'd0) hs_cnt++;
      if (gd.ls) begin
        if (last_ls_d >= 0) check("line_period", 64'(cyc - last_ls_d), 64'd1056);
        last_ls_d = cyc;
        ls_cnt_d++;
      end
      if (pd.h == 11'd1055 && pd.v == 11'd10) begin
        check("lwrap_h", 64'(gd.h), 64'd0);
        check("lwrap_v", 64'(gd.v), 64'd11);
        check("lwrap_ls", 64'(gd.ls), 64'd1);
        check("lwrap_fs", 64'(gd.fs), 64'd0);
        lwrap_seen = 1;
      end
      if (gs.ls) begin
        if (gs.fs) begin
          if (last_fs_s >= 0) begin
            check("frame_period", 64'(cyc - last_fs_s), 64'd198);
            check("lines_per_frame", 64'(ls_in_frame), 64'd11);
          end
          last_fs_s = cyc;
          ls_in_frame = 1;
        end else begin
          ls_in_frame++;
        end
      end
      if (gs.fs && (cyc - rel_cyc) < 594) fs_win++;
      if (gs.vs) check("vsync_range", 64'(gs.v >= 11'd7 && gs.v <= 11'd8), 64'd1);
      if (ps.h == 11'd17 && ps.v == 11'd10) begin
        check("fwrap_hv", 64'({gs.h, gs.v}), 64'd0);
        check("fwrap_fs", 64'(gs.fs), 64'd1);
        fwrap_cnt++;
      end
    end
    pd = gd;
    ps = gs;
  endtask

  initial begin
    vga_t first_exp;
    first_exp = '0;
    first_exp.ls = 1'b1;
    first_exp.fs = 1'b1;
    pd = '0;
    ps = '0;
    rst = 1'b1;

    repeat (3) cycle(1'b1);
    check("reset_def", 64'(gd), 64'd0);
    check("reset_small", 64'(gs), 64'd0);

    repeat (137) cycle(1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1);
      check("midrst_def", 64'(gd), 64'd0);
      check("midrst_small", 64'(gs), 64'd0);
    end

    track_en = 1;
    cycle(1'b0);
    check("first_def", 64'(gd), 64'(first_exp));
    check("first_small", 64'(gs), 64'(first_exp));

    repeat (12 * 1056 + 40) cycle(1'b0);

    check("hsync_width", 64'(hs_cnt), 64'd128);
    check("line_starts", 64'(ls_cnt_d), 64'd13);
    check("lwrap_seen", 64'(lwrap_seen), 64'd1);
    check("fs_in_3_frames", 64'(fs_win), 64'd3);
    check("fwrap_seen", 64'(fwrap_cnt > 0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
